muldiv_sched: RTL and testbench
===============================

Name: muldiv_sched

Overview:
- Scheduler in the EX stage of the dual-issue pipeline.
- Shares one external multi-cycle mul/div unit between pipe 0 and pipe 1.
- Serialises requests in program order, pipe 0 first, and captures the 64-bit results per pipe.
- Drives stall_from_ex into the pipeline controller until every mul/div in the current EX bundle has completed.
- Aborts in-flight work when EX is flushed (exception or mispredict).

Parameters:
- DATA_W, 32, operand width.
- OP_W, 3, width of muldiv_op_t; encodings are fixed in the package.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req  in  2  pipe i's EX instruction is valid and needs the mul/div unit
- op  in  2xOP_W  muldiv_op_t per pipe
- opa  in  2xDATA_W  operand A per pipe
- opb  in  2xDATA_W  operand B per pipe
- stall_ex  in  1  EX stage held this cycle (from pipeline controller)
- flush_ex  in  1  EX stage flushed this cycle
- stall_req  out  1  to pipeline controller as stall_from_ex
- result_valid  out  2  result[i] holds a completed result for the current bundle
- result  out  2x2*DATA_W  {hi,lo} per pipe
- unit_start  out  1  one-cycle start pulse to the unit
- unit_op  out  OP_W  operation for unit_start
- unit_a  out  DATA_W  operand A for unit_start
- unit_b  out  DATA_W  operand B for unit_start
- unit_abort  out  1  one-cycle kill pulse to the unit
- unit_done  in  1  one-cycle completion pulse
- unit_result  in  2*DATA_W  valid when unit_done

Behaviour:
- Reset (async):
  - State IDLE; done[1:0]=0; result registers 0.
  - unit_start, unit_abort, stall_req, result_valid all 0; unit_op/unit_a/unit_b 0.
- pending[i] = req[i] & ~done[i]. stall_req = |pending & ~flush_ex (combinational).
- result_valid = done. result[i] is registered.
- FSM states: IDLE, ISSUE, BUSY.
  - IDLE:
    - If flush_ex, stay IDLE.
    - Else if |pending, latch sel = lowest i with pending[i] and latch that pipe's op/operands; go to ISSUE.
  - ISSUE:
    - Assert unit_start with the latched op/operands for exactly one cycle; go to BUSY.
    - If flush_ex, go to IDLE without asserting unit_start.
  - BUSY:
    - On unit_done: result[sel] <= unit_result; done[sel] <= 1; go to IDLE.
    - Next pending pipe (pipe 1) is picked from IDLE the following cycle.
- Latency:
  - req at cycle T → unit_start at T+1.
  - unit_done at T+1+k (k>=1) → result_valid[sel] and stall_req low at T+2+k, if nothing else is pending.
  - Two requests in one bundle: pipe 1 start occurs 2 cycles after pipe 0's done.
- Bundle advance:
  - Whenever stall_ex==0 at a clock edge, done[1:0] <= 0, because the bundle leaves EX.
  - stall_ex high with all done (downstream MM stall): results are held; nothing is re-issued.
- Flush (highest priority):
  - flush_ex at any edge clears done, returns to IDLE, and discards any unit_done in that same cycle.
  - If state is ISSUE or BUSY with no unit_done that cycle, unit_abort pulses 1 cycle (registered, next cycle).
  - No unit_start is issued in the cycle unit_abort is high.
- Intra-bundle dependencies (pipe 1 reading pipe 0's hi/lo) are excluded by issue logic; the block does not forward between pipes.
- unit_done in IDLE or ISSUE (spurious) is ignored.
- req dropping while BUSY without flush is illegal; covered by assertion.
- Reset mid-operation clears everything; unit_abort is not asserted because the unit shares rst.

Decomposition:
- Package (cpu_defs): muldiv_op_t enum (MUL, MULU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU), hilo_t {hi,lo} struct, muldiv_state_t enum.
- One sub-module is natural: muldiv_pick, a 2-way fixed-priority picker producing sel and any-pending.
- Everything else lives in one always_ff FSM plus small combinational logic.

Test Plan:
- Single req=01, op=MUL, opa=3, opb=5; unit returns done k=2 with {0,15} → unit_start at T+1, result_valid=01 and result[0]={0,15} at T+4, stall_req high T..T+3.
- req=11 (DIV 7/2 on pipe 0, MULU 0xFFFFFFFF*2 on pipe 1) → two starts, pipe 0 first; result[0]={1,3}, result[1]={1,0xFFFFFFFE}; stall_req low only after both done.
- flush_ex in BUSY, 3 cycles after start → unit_abort pulses once next cycle, done=00, stall_req=0, late unit_done ignored.
- flush_ex coincident with unit_done → result discarded, result_valid=00, no unit_abort.
- stall_ex held 4 cycles after completion (MM stall) → result_valid and result stable, no new unit_start; done clears at first edge with stall_ex=0.
- rst asserted mid-BUSY, asynchronously → all outputs 0 immediately; after release, req=01 is re-issued cleanly with unit_start at +1.

Source files
------------

// File: rtl/muldiv_sched_pkg.sv
// Shared types for the EX-stage mul/div scheduler: operation encodings,
// hi/lo result layout and scheduler FSM states.
package muldiv_sched_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        MUL   = 3'd0,
        MULU  = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MADD  = 3'd4,
        MADDU = 3'd5,
        MSUB  = 3'd6,
        MSUBU = 3'd7
    } muldiv_op_t;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_sched_if.sv
// Start/abort/done bus between the scheduler and the shared multi-cycle mul/div unit.
interface muldiv_sched_if #(parameter int DATA_W = 32);
    import muldiv_sched_pkg::*;

    logic                unit_start;
    muldiv_op_t          unit_op;
    logic [DATA_W-1:0]   unit_a;
    logic [DATA_W-1:0]   unit_b;
    logic                unit_abort;
    logic                unit_done;
    logic [2*DATA_W-1:0] unit_result;

    modport master (
        output unit_start, unit_op, unit_a, unit_b, unit_abort,
        input  unit_done, unit_result
    );

    modport slave (
        input  unit_start, unit_op, unit_a, unit_b, unit_abort,
        output unit_done, unit_result
    );

endinterface

// File: rtl/muldiv_sched_pick.sv
// Two-way fixed-priority picker: pipe 0 wins whenever it is pending.
module muldiv_sched_pick (
    input  logic [1:0] pending,
    output logic       sel,
    output logic       any
);

    assign sel = ~pending[0];
    assign any = |pending;

endmodule

// File: rtl/muldiv_sched.sv
// EX-stage scheduler sharing one multi-cycle mul/div unit between pipe 0 and
// pipe 1, serialising requests in program order and stalling EX until done.
module muldiv_sched
    import muldiv_sched_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 req,
    input  muldiv_op_t [1:0]           op,
    input  logic [1:0][DATA_W-1:0]     opa,
    input  logic [1:0][DATA_W-1:0]     opb,
    input  logic                       stall_ex,
    input  logic                       flush_ex,
    output logic                       stall_req,
    output logic [1:0]                 result_valid,
    output logic [1:0][2*DATA_W-1:0]   result,
    muldiv_sched_if.master             unit
);

    muldiv_state_t     state;
    logic [1:0]        done;
    logic [1:0]        pending;
    logic              pick_sel;
    logic              pick_any;
    logic              sel_q;
    muldiv_op_t        lat_op;
    logic [DATA_W-1:0] lat_a;
    logic [DATA_W-1:0] lat_b;
    logic              abort_q;

    assign pending      = req & ~done;
    assign stall_req    = (|pending) & ~flush_ex & ~rst;
    assign result_valid = done;

    muldiv_sched_pick u_pick (
        .pending (pending),
        .sel     (pick_sel),
        .any     (pick_any)
    );

    // Start is decoded from ISSUE so it lands one cycle after the request,
    // and a flush in that same cycle can still suppress it.
    assign unit.unit_start = (state == S_ISSUE) && !flush_ex;
    assign unit.unit_op    = lat_op;
    assign unit.unit_a     = lat_a;
    assign unit.unit_b     = lat_b;
    assign unit.unit_abort = abort_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            done    <= '0;
            result  <= '0;
            sel_q   <= 1'b0;
            lat_op  <= MUL;
            lat_a   <= '0;
            lat_b   <= '0;
            abort_q <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            if (!stall_ex) begin
                done <= '0;
            end
            if (flush_ex) begin
                state   <= S_IDLE;
                done    <= '0;
                abort_q <= ((state == S_ISSUE) || (state == S_BUSY)) && !unit.unit_done;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (pick_any) begin
                            sel_q  <= pick_sel;
                            lat_op <= op[pick_sel];
                            lat_a  <= opa[pick_sel];
                            lat_b  <= opb[pick_sel];
                            state  <= S_ISSUE;
                        end
                    end
                    S_ISSUE: state <= S_BUSY;
                    S_BUSY: begin
                        if (unit.unit_done) begin
                            result[sel_q] <= unit.unit_result;
                            done[sel_q]   <= 1'b1;
                            state         <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // The owning instruction must stay in EX while its operation is in flight.
    req_held_while_busy: assert property (
        @(posedge clk) disable iff (rst)
        ((state == S_BUSY) && !flush_ex) |-> req[sel_q]
    );

endmodule

// File: tb/tb_muldiv_sched.sv
// Scoreboard bench for muldiv_sched with a behavioural mul/div unit.
module tb_muldiv_sched;
    import muldiv_sched_pkg::*;

    logic                 clk;
    logic                 rst;
    logic [1:0]           req;
    muldiv_op_t [1:0]     op;
    logic [1:0][31:0]     opa;
    logic [1:0][31:0]     opb;
    logic                 stall_ex;
    logic                 flush_ex;
    logic                 mm_stall;
    logic                 stall_req;
    logic [1:0]           result_valid;
    logic [1:0][63:0]     result;

    typedef struct {
        int          pipe;
        logic [63:0] val;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;

    muldiv_sched_if #(.DATA_W(32)) unit_bus ();

    muldiv_sched #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .op           (op),
        .opa          (opa),
        .opb          (opb),
        .stall_ex     (stall_ex),
        .flush_ex     (flush_ex),
        .stall_req    (stall_req),
        .result_valid (result_valid),
        .result       (result),
        .unit         (unit_bus)
    );

    // Pipeline controller: holds EX on the scheduler's request or an MM stall.
    assign stall_ex = stall_req | mm_stall;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] unit_calc(muldiv_op_t o, logic [31:0] a, logic [31:0] b);
        logic signed [63:0] sa, sb_;
        sa  = {{32{a[31]}}, a};
        sb_ = {{32{b[31]}}, b};
        case (o)
            MUL:  return sa * sb_;
            MULU: return {32'd0, a} * {32'd0, b};
            DIV:  return (b == 0) ? 64'd0 : {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
            DIVU: return (b == 0) ? 64'd0 : {a % b, a / b};
            default: return 64'd0;
        endcase
    endfunction

    task automatic wait_start(input string tag, input int exp_n);
        int n = 0;
        while (!unit_bus.unit_start && n < 20) begin
            tick();
            n++;
        end
        check(tag, 64'(n), 64'(exp_n));
    endtask

    // Called in the start cycle; pulses done k cycles later, returns in the cycle after done.
    task automatic serve(input int k);
        muldiv_op_t  o;
        logic [31:0] a, b;
        o = unit_bus.unit_op;
        a = unit_bus.unit_a;
        b = unit_bus.unit_b;
        repeat (k) tick();
        check("stall_busy", stall_req, 1);
        unit_bus.unit_done   = 1'b1;
        unit_bus.unit_result = unit_calc(o, a, b);
        tick();
        unit_bus.unit_done   = 1'b0;
        unit_bus.unit_result = '0;
        #1;
    endtask

    logic [1:0] prev_valid;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (result_valid[i] && !prev_valid[i]) begin
                    if (sb.size() == 0) begin
                        check("sb_unexpected", 64'(i), 64'hFFFF);
                    end else begin
                        sb_t e;
                        e = sb.pop_front();
                        check("sb_pipe", 64'(i), 64'(e.pipe));
                        check("sb_result", result[i], e.val);
                    end
                end
            end
            prev_valid <= result_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = '0; op = '{MUL, MUL}; opa = '0; opb = '0;
        flush_ex = 1'b0; mm_stall = 1'b0;
        unit_bus.unit_done = 1'b0; unit_bus.unit_result = '0;
        repeat (2) tick();
        check("rst_stall", stall_req, 0);
        check("rst_valid", result_valid, 0);
        check("rst_start", unit_bus.unit_start, 0);
        check("rst_abort", unit_bus.unit_abort, 0);
        check("rst_unit_op", unit_bus.unit_op, 0);
        rst = 1'b0;
        tick();

        // single MUL 3*5
        tick();
        req = 2'b01; op[0] = MUL; opa[0] = 32'd3; opb[0] = 32'd5;
        sb.push_back('{0, hilo_t'{hi: 32'd0, lo: 32'd15}});
        #1;
        check("t1_stall_T", stall_req, 1);
        check("t1_start_T", unit_bus.unit_start, 0);
        wait_start("t1_start_lat", 1);
        check("t1_unit_op", unit_bus.unit_op, MUL);
        check("t1_unit_a", unit_bus.unit_a, 3);
        check("t1_unit_b", unit_bus.unit_b, 5);
        serve(2);
        check("t1_valid", result_valid, 2'b01);
        check("t1_stall_done", stall_req, 0);
        req = 2'b00;
        tick();
        check("t1_valid_clr", result_valid, 0);

        // dual bundle: DIV on pipe 0, MULU on pipe 1
        tick();
        req = 2'b11;
        op[0] = DIV;  opa[0] = 32'd7;          opb[0] = 32'd2;
        op[1] = MULU; opa[1] = 32'hFFFF_FFFF;  opb[1] = 32'd2;
        sb.push_back('{0, hilo_t'{hi: 32'd1, lo: 32'd3}});
        sb.push_back('{1, hilo_t'{hi: 32'd1, lo: 32'hFFFF_FFFE}});
        #1;
        wait_start("t2_p0_lat", 1);
        check("t2_p0_op", unit_bus.unit_op, DIV);
        check("t2_p0_a", unit_bus.unit_a, 7);
        serve(3);
        check("t2_valid_p0", result_valid, 2'b01);
        check("t2_stall_mid", stall_req, 1);
        wait_start("t2_p1_gap", 1);
        check("t2_p1_op", unit_bus.unit_op, MULU);
        check("t2_p1_a", unit_bus.unit_a, 32'hFFFF_FFFF);
        serve(1);
        check("t2_valid_both", result_valid, 2'b11);
        check("t2_stall_done", stall_req, 0);
        req = 2'b00;
        tick();
        check("t2_valid_clr", result_valid, 0);

        // flush while BUSY, then a late done
        tick();
        req = 2'b01; op[0] = MUL; opa[0] = 32'd2; opb[0] = 32'd2;
        #1;
        wait_start("t3_start_lat", 1);
        repeat (3) tick();
        flush_ex = 1'b1;
        #1;
        check("t3_stall_flush", stall_req, 0);
        tick();
        flush_ex = 1'b0; req = 2'b00;
        #1;
        check("t3_abort", unit_bus.unit_abort, 1);
        check("t3_no_start", unit_bus.unit_start, 0);
        check("t3_valid", result_valid, 0);
        tick();
        check("t3_abort_once", unit_bus.unit_abort, 0);
        unit_bus.unit_done = 1'b1; unit_bus.unit_result = 64'hDEAD;
        tick();
        unit_bus.unit_done = 1'b0; unit_bus.unit_result = '0;
        #1;
        check("t3_late_done", result_valid, 0);
        tick();
        check("t3_late_start", unit_bus.unit_start, 0);

        // flush coincident with done
        tick();
        req = 2'b01; op[0] = MUL; opa[0] = 32'd4; opb[0] = 32'd4;
        #1;
        wait_start("t4_start_lat", 1);
        tick();
        unit_bus.unit_done = 1'b1; unit_bus.unit_result = 64'd16; flush_ex = 1'b1;
        tick();
        unit_bus.unit_done = 1'b0; unit_bus.unit_result = '0; flush_ex = 1'b0; req = 2'b00;
        #1;
        check("t4_valid", result_valid, 0);
        check("t4_no_abort", unit_bus.unit_abort, 0);
        tick();
        check("t4_valid_after", result_valid, 0);

        // MM stall holds completed results
        tick();
        req = 2'b01; op[0] = MULU; opa[0] = 32'd6; opb[0] = 32'd7;
        sb.push_back('{0, hilo_t'{hi: 32'd0, lo: 32'd42}});
        #1;
        wait_start("t5_start_lat", 1);
        serve(2);
        mm_stall = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("t5_hold_valid", result_valid, 2'b01);
            check("t5_hold_result", result[0], 64'd42);
            check("t5_hold_start", unit_bus.unit_start, 0);
            if (i < 3) tick();
        end
        mm_stall = 1'b0; req = 2'b00;
        tick();
        check("t5_valid_clr", result_valid, 0);

        // async reset mid-BUSY, then clean re-issue
        tick();
        req = 2'b01; op[0] = MUL; opa[0] = 32'd9; opb[0] = 32'd9;
        #1;
        wait_start("t6_start_lat", 1);
        tick();
        #2 rst = 1'b1;
        #1;
        check("t6_rst_stall", stall_req, 0);
        check("t6_rst_valid", result_valid, 0);
        check("t6_rst_result", result[0], 0);
        check("t6_rst_start", unit_bus.unit_start, 0);
        check("t6_rst_abort", unit_bus.unit_abort, 0);
        check("t6_rst_a", unit_bus.unit_a, 0);
        tick();
        rst = 1'b0;
        sb.push_back('{0, hilo_t'{hi: 32'd0, lo: 32'd81}});
        #1;
        wait_start("t6_restart_lat", 1);
        check("t6_restart_a", unit_bus.unit_a, 9);
        serve(1);
        check("t6_valid", result_valid, 2'b01);
        req = 2'b00;
        repeat (2) tick();

        check("sb_empty", 64'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
